// File: rtl/ps2_device_tx.sv
// PS/2 device-to-host byte transmitter with a byte FIFO; PARITY_ERR_INJ via macro PS2_PARITY_ERR_INJ_EN.
// Latency: frame starts after CLK_HALF released-clock cycles; 22*CLK_HALF cycles per frame.
// Backpressure: in_ready drops when the FIFO holds FIFO_DEPTH bytes; host inhibit aborts and retries.

module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_vld,
   input  logic [WIDTH-1:0] wr_dat,
   output logic             wr_rdy,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_dat,
   output logic [CW-1:0]    count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   assign wr_rdy = (count < CW'(DEPTH));
   assign push   = wr_vld && wr_rdy;
   assign pop    = rd_en && (count != '0);
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_dat;
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

module ps2_device_tx #(
   parameter int CLK_HALF   = 810,
   parameter int FIFO_DEPTH = 8,
   parameter int GAP_CYCLES = 2700
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [7:0]                        in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              ps2_clk_in,
   output logic                              ps2_clk_oe,
   output logic                              ps2_data_oe,
   input  logic                              inj_parity_err,
   output logic                              busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              done,
   output logic                              abort
);
   localparam int CNT_MAX = (CLK_HALF > GAP_CYCLES) ? CLK_HALF : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HALF - 1);
   localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

   typedef enum logic [2:0] {IDLE, WAIT_BUS, HIGH, LOW, GAP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic          done_q, abort_q;
   logic          pop, frame_done, frame_abort, inhibit, frame_start;
   logic [7:0]    head_dat;
   logic          par_inv;
   logic [10:0]   frame;
   logic          tx_bit;

   fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (in_valid),
      .wr_dat (in_data),
      .wr_rdy (in_ready),
      .rd_en  (pop),
      .rd_dat (head_dat),
      .count  (fifo_count)
   );

`ifdef PS2_PARITY_ERR_INJ_EN
   logic pend_q, inv_q;

   // The request is latched into the frame at bit 0 so a mid-frame pulse targets the next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= 1'b0;
         inv_q  <= 1'b0;
      end else begin
         if (frame_start) inv_q <= pend_q;
         if (inj_parity_err)                              pend_q <= 1'b1;
         else if ((frame_done || frame_abort) && inv_q)   pend_q <= 1'b0;
      end
   end
   assign par_inv = inv_q;
`else
   logic inj_unused;
   assign inj_unused = inj_parity_err;
   assign par_inv    = 1'b0;
`endif

   assign frame       = {1'b1, (~^head_dat) ^ par_inv, head_dat, 1'b0};
   assign tx_bit      = frame[bit_q];
   assign inhibit     = (state_q == HIGH) && (cnt_q >= CW'(2)) && !ps2_clk_in && (bit_q <= 4'd9);
   assign frame_start = (state_q == WAIT_BUS) && (state_d == HIGH);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      pop         = 1'b0;
      frame_done  = 1'b0;
      frame_abort = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (fifo_count != '0) state_d = WAIT_BUS;
         end
         WAIT_BUS: begin
            if (!ps2_clk_in) begin
               cnt_d = '0;
            end else if (cnt_q == HALF_LAST) begin
               state_d = HIGH;
               cnt_d   = '0;
               bit_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HIGH: begin
            if (inhibit) begin
               frame_abort = 1'b1;
               state_d     = WAIT_BUS;
               cnt_d       = '0;
            end else if (cnt_q == HALF_LAST) begin
               state_d = LOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LOW: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (bit_q == 4'd10) begin
                  state_d    = GAP;
                  pop        = 1'b1;
                  frame_done = 1'b1;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  state_d = HIGH;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= 4'd0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         done_q  <= frame_done;
         abort_q <= frame_abort;
      end
   end

   assign ps2_clk_oe  = (state_q == LOW);
   assign ps2_data_oe = ((state_q == HIGH) || (state_q == LOW)) && !tx_bit;
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign abort       = abort_q;
endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx: decodes frames off the open-drain lines and checks hand-computed values.
module tb_ps2_device_tx;
   localparam int CLK_HALF = 4;
   localparam int DEPTH    = 4;
   localparam int GAP      = 10;
   localparam int CW       = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          ps2_clk_in;
   logic          ps2_clk_oe;
   logic          ps2_data_oe;
   logic          inj_parity_err = 1'b0;
   logic          busy;
   logic [CW-1:0] fifo_count;
   logic          done;
   logic          abort;
   logic          host_hold = 1'b0;

   assign ps2_clk_in = !ps2_clk_oe && !host_hold;
   always #5 clk = ~clk;

   ps2_device_tx #(.CLK_HALF(CLK_HALF), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .ps2_clk_in     (ps2_clk_in),
      .ps2_clk_oe     (ps2_clk_oe),
      .ps2_data_oe    (ps2_data_oe),
      .inj_parity_err (inj_parity_err),
      .busy           (busy),
      .fifo_count     (fifo_count),
      .done           (done),
      .abort          (abort)
   );

   typedef struct {
      logic [7:0]  dat;
      logic        par;
      logic [10:0] oe_seq;
      int          len;
      int          cnt_after;
      int          nbits;
   } frame_t;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   frame_t      frames[$];
   frame_t      mf;
   int          nbits = 0;
   logic [10:0] oe_seq = '0;
   int          start_cyc = 0;
   int          last_done_cyc = 0;
   int          min_gap = 1 << 30;
   bit          have_done = 0;
   int          done_cnt = 0;
   int          abort_cnt = 0;
   logic [1:0]  abort_oe = 2'b11;
   logic        prev_clk_oe = 1'b0;
   logic        prev_data_oe = 1'b0;
   bit          full_seen = 0;
   int          cnt_at_full = 0;
   bit          track_min = 0;
   int          min_cnt = 99;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         nbits = 0;
      end else begin
         if (nbits == 0 && ps2_data_oe && !prev_data_oe) begin
            start_cyc = cyc;
            if (have_done && (cyc - last_done_cyc) < min_gap) min_gap = cyc - last_done_cyc;
         end
         if (ps2_clk_oe && !prev_clk_oe && nbits < 11) begin
            oe_seq[nbits] = ps2_data_oe;
            nbits++;
         end
         if (track_min && !done && fifo_count < min_cnt) min_cnt = fifo_count;
         if (done) begin
            mf.dat       = ~oe_seq[8:1];
            mf.par       = ~oe_seq[9];
            mf.oe_seq    = oe_seq;
            mf.len       = cyc - start_cyc;
            mf.cnt_after = fifo_count;
            mf.nbits     = nbits;
            frames.push_back(mf);
            nbits = 0;
            done_cnt++;
            have_done = 1;
            last_done_cyc = cyc;
         end
         if (abort) begin
            abort_cnt++;
            abort_oe = {ps2_clk_oe, ps2_data_oe};
            nbits = 0;
         end
         if (in_valid && !in_ready) begin
            full_seen = 1;
            cnt_at_full = fifo_count;
         end
      end
      prev_clk_oe  = ps2_clk_oe;
      prev_data_oe = ps2_data_oe;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      for (int k = 0; k < 600 && !in_ready; k++) tick();
      check("push_ready", in_ready, 1);
      tick();
   endtask

   task automatic next_frame(input string tag, output frame_t fr);
      for (int k = 0; k < 600 && frames.size() == 0; k++) tick();
      check({tag, "_arrived"}, frames.size() != 0, 1);
      fr = '{default: 0};
      if (frames.size() != 0) fr = frames.pop_front();
   endtask

   initial begin
      frame_t      f;
      int          rel;
      int          a0;
      int          d0;
      bit          found;
      logic [7:0]  six [6];
      six = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

      repeat (3) tick();
      check("rst_count", fifo_count, 0);
      check("rst_ready", in_ready, 1);
      check("rst_clk_oe", ps2_clk_oe, 0);
      check("rst_data_oe", ps2_data_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_abort", abort, 0);
      rst = 1'b0;
      tick();

      // Single frame: bit pattern, parity and exact length.
      push(8'hFA);
      in_valid = 1'b0;
      repeat (20) tick();
      check("fa_busy", busy, 1);
      next_frame("fa", f);
      check("fa_data", f.dat, 8'hFA);
      check("fa_par", f.par, 1);
      check("fa_oe_seq", f.oe_seq, 11'h00B);
      check("fa_nbits", f.nbits, 11);
      check("fa_len", f.len, 88);
      check("fa_count", f.cnt_after, 0);

      // Three back-to-back bytes.
      min_gap = 1 << 30;
      push(8'h09);
      push(8'h05);
      push(8'hFD);
      in_valid = 1'b0;
      check("b2b_count3", fifo_count, 3);
      next_frame("b2b0", f);
      check("b2b0_data", f.dat, 8'h09);
      check("b2b0_par", f.par, 1);
      check("b2b0_count", f.cnt_after, 2);
      next_frame("b2b1", f);
      check("b2b1_data", f.dat, 8'h05);
      check("b2b1_par", f.par, 1);
      check("b2b1_count", f.cnt_after, 1);
      next_frame("b2b2", f);
      check("b2b2_data", f.dat, 8'hFD);
      check("b2b2_par", f.par, 0);
      check("b2b2_count", f.cnt_after, 0);
      check("b2b_gap_ok", min_gap >= GAP, 1);

      // Host inhibit during bit 5 HIGH.
      a0 = abort_cnt;
      push(8'hAA);
      in_valid = 1'b0;
      found = 0;
      for (int k = 0; k < 600 && !found; k++) begin
         if (nbits == 5 && !ps2_clk_oe && busy) found = 1;
         else tick();
      end
      check("inh_bit5_seen", found, 1);
      track_min = 1;
      min_cnt = 99;
      host_hold = 1'b1;
      repeat (10) tick();
      host_hold = 1'b0;
      rel = cyc;
      check("inh_abort_cnt", abort_cnt - a0, 1);
      check("inh_abort_oe", abort_oe, 2'b00);
      next_frame("inh", f);
      track_min = 0;
      check("inh_data", f.dat, 8'hAA);
      check("inh_par", f.par, 1);
      check("inh_len", f.len, 88);
      check("inh_wait_high", (start_cyc - rel) >= CLK_HALF, 1);
      check("inh_min_count", min_cnt >= 1, 1);

      // Fill past depth with in_valid held.
      full_seen = 0;
      for (int i = 0; i < 6; i++) push(six[i]);
      in_valid = 1'b0;
      check("full_seen", full_seen, 1);
      check("full_count", cnt_at_full, DEPTH);
      for (int i = 0; i < 6; i++) begin
         next_frame("order", f);
         check("order_data", f.dat, six[i]);
      end

      // Parity-error injection request.
      inj_parity_err = 1'b1;
      tick();
      inj_parity_err = 1'b0;
      push(8'h00);
      push(8'h00);
      in_valid = 1'b0;
      next_frame("inj0", f);
      check("inj0_data", f.dat, 8'h00);
`ifdef PS2_PARITY_ERR_INJ_EN
      check("inj0_par", f.par, 0);
`else
      check("inj0_par", f.par, 1);
`endif
      next_frame("inj1", f);
      check("inj1_par", f.par, 1);

      // Reset during bit 3 LOW.
      push(8'h3C);
      push(8'h55);
      in_valid = 1'b0;
      found = 0;
      for (int k = 0; k < 600 && !found; k++) begin
         if (nbits == 4 && ps2_clk_oe) found = 1;
         else tick();
      end
      check("mid_bit3_seen", found, 1);
      d0 = done_cnt;
      a0 = abort_cnt;
      rst = 1'b1;
      tick();
      check("mid_clk_oe", ps2_clk_oe, 0);
      check("mid_data_oe", ps2_data_oe, 0);
      check("mid_count", fifo_count, 0);
      check("mid_done", done, 0);
      check("mid_busy", busy, 0);
      rst = 1'b0;
      repeat (40) tick();
      check("mid_no_done", done_cnt - d0, 0);
      check("mid_no_abort", abort_cnt - a0, 0);
      check("mid_no_frames", frames.size(), 0);
      check("mid_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ps2_device_tx.md
PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

Interface
REQ-001 Parameter CLK_HALF, default 810: system-clock cycles per PS/2 clock half-period (30 us at 27 MHz); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8: byte FIFO entries; power of two, 2..64.
REQ-003 Parameter GAP_CYCLES, default 2700: minimum released-bus cycles between frames.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  8  byte to transmit.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  FIFO can accept a byte.
REQ-009 ps2_clk_in  input  1  sampled PS/2 clock line, already synchronised.
REQ-010 ps2_clk_oe  output  1  1 = drive PS/2 clock low, 0 = release it.
REQ-011 ps2_data_oe  output  1  1 = drive PS/2 data low, 0 = release it.
REQ-012 inj_parity_err  input  1  request an inverted parity bit on the next frame started.
REQ-013 busy  output  1  frame in progress or GAP_CYCLES wait active.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH+1)  bytes queued, including the byte in flight.
REQ-015 done  output  1  one-cycle pulse when a frame completes.
REQ-016 abort  output  1  one-cycle pulse when a host inhibit kills a frame.

Function
REQ-017 Handshake: byte accepted on a cycle with in_valid=1 and in_ready=1; in_ready = (fifo_count < FIFO_DEPTH).
REQ-018 Simultaneous accept and completion: fifo_count unchanged; a push when full is ignored.
REQ-019 FSM states: IDLE, WAIT_BUS, HIGH, LOW, GAP.
REQ-020 IDLE -> WAIT_BUS when fifo_count > 0.
REQ-021 WAIT_BUS: ps2_clk_in must read 1 for CLK_HALF consecutive cycles, then HIGH with bit index 0; any low resets the count.
REQ-022 Frame: 11 bits, in order start(0), data LSB first, odd parity (~^data), stop(1).
REQ-023 HIGH: data_oe = ~bit, clk_oe = 0, held CLK_HALF cycles.
REQ-024 LOW: data unchanged, clk_oe = 1, held CLK_HALF cycles; then bit index +1 and back to HIGH, or GAP after bit 10.
REQ-025 Frame length is exactly 22*CLK_HALF cycles from HIGH entry to GAP entry.
REQ-026 Leaving LOW after bit 10: FIFO head popped, done pulses, both oe outputs = 0.
REQ-027 GAP: lines released for GAP_CYCLES, then IDLE.
REQ-028 Inhibit: ps2_clk_in = 0 sampled in HIGH after its first 2 cycles, for bits 0..9.
REQ-029 On inhibit: abort pulses, both oe outputs = 0, head byte kept (not popped), next state WAIT_BUS; the byte is retransmitted from bit 0.
REQ-030 Inhibit during bit 10 is ignored; the frame completes normally.
REQ-031 FIFO read/write pointers wrap modulo FIFO_DEPTH.
REQ-032 busy = 1 in WAIT_BUS, HIGH, LOW and GAP.

Reset
REQ-033 rst = 1 forces, next edge: state IDLE, FIFO empty (fifo_count=0), in_ready=1, ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, abort=0, pending parity-error flag cleared.
REQ-034 Reset mid-frame: lines released the next cycle, no done or abort pulse, queued bytes discarded.

Configuration
REQ-035 Macro PS2_PARITY_ERR_INJ_EN defined: inj_parity_err=1 sets a pending flag; the next frame to reach bit 0 sends ~(~^data) as parity; the flag clears at that frame's done or abort.
REQ-036 Macro undefined: inj_parity_err is ignored and parity is always odd.

Verification
REQ-037 CLK_HALF=4, push 0xFA -> data_oe sequence over bits 0..10 = 1,1,0,1,0,0,0,0,0,0,0; parity 1; done at cycle 88 after HIGH entry.
REQ-038 Push 0x09, 0x05, 0xFD back-to-back -> three frames, parity bits 1,1,0; each pair of frames separated by GAP_CYCLES or more; fifo_count goes 3,2,1,0.
REQ-039 Push 0xAA, then hold ps2_clk_in=0 for 10 cycles during bit 5 HIGH -> abort pulse, lines released, 0xAA retransmitted in full after the line has been high for CLK_HALF cycles; fifo_count never drops below 1 before done.
REQ-040 FIFO_DEPTH=4, push 6 bytes with in_valid held -> in_ready low at count 4; pushes resume as frames drain; output order preserved.
REQ-041 PS2_PARITY_ERR_INJ_EN defined, pulse inj_parity_err, push 0x00 then 0x00 -> first parity bit 0, second parity bit 1.
REQ-042 Assert rst during bit 3 LOW -> oe outputs 0 the next cycle, fifo_count=0, no done pulse.
